// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants: opcodes, ALU operations, transfer sizes, decode helpers.
// Pure declarations, no state.
// Used by the core and its register file.
package legv8_pkg;

    // 11-bit opcodes
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_STURB = 11'b00111000000;
    // shorter opcodes
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;

    localparam logic [4:0]  COND_LT  = 5'h0B;

    localparam logic [3:0]  XFER_NONE  = 4'd0;
    localparam logic [3:0]  XFER_BYTE  = 4'd1;
    localparam logic [3:0]  XFER_DWORD = 4'd8;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_EOR, ALU_LSL, ALU_LSR, ALU_PASSB
    } alu_op_t;

    typedef enum logic [4:0] {
        I_NOP, I_ADDS, I_SUBS, I_AND, I_EOR, I_LSL, I_LSR, I_BR,
        I_LDUR, I_LDURB, I_STUR, I_STURB, I_ADDI, I_CBZ, I_BCOND, I_B, I_BL
    } instr_kind_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    // Longest opcode wins; anything unrecognised falls through to NOP.
    function automatic instr_kind_t decode(input logic [10:0] op);
        instr_kind_t k;
        case (op)
            OP_ADDS:  k = I_ADDS;
            OP_SUBS:  k = I_SUBS;
            OP_AND:   k = I_AND;
            OP_EOR:   k = I_EOR;
            OP_LSL:   k = I_LSL;
            OP_LSR:   k = I_LSR;
            OP_BR:    k = I_BR;
            OP_LDUR:  k = I_LDUR;
            OP_LDURB: k = I_LDURB;
            OP_STUR:  k = I_STUR;
            OP_STURB: k = I_STURB;
            default:  k = I_NOP;
        endcase
        if (k == I_NOP) begin
            if (op[10:1] == OP_ADDI)       k = I_ADDI;
            else if (op[10:3] == OP_CBZ)   k = I_CBZ;
            else if (op[10:3] == OP_BCOND) k = I_BCOND;
            else if (op[10:5] == OP_B)     k = I_B;
            else if (op[10:5] == OP_BL)    k = I_BL;
        end
        return k;
    endfunction

    // Only LT is implemented; every other condition is never taken.
    function automatic logic cond_taken(input flags_t f, input logic [4:0] cond);
        return (cond == COND_LT) && (f.n != f.v);
    endfunction

endpackage

// File: rtl/legv8_core_reg_file.sv
// 32x64 register file, X31 hard-wired to zero, two combinational reads, one write.
// Reads are combinational; the write lands at the rising edge (read-old-value same cycle).
// No backpressure; a write is accepted every cycle.
module reg_file_32x64
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [63:0] rd1,
    output logic [63:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [63:0] wd
);
    logic [63:0] regs [0:30];

    assign rd1 = (ra1 == 5'd31) ? 64'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd31) ? 64'd0 : regs[ra2];

    // Clear all registers on reset; writes to X31 are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 31; i++) begin
                regs[i] <= 64'd0;
            end
        end else if (we && (wa != 5'd31)) begin
            regs[wa] <= wd;
        end
    end
endmodule

// File: rtl/legv8_core.sv
// Single-cycle LEGv8 core: fetch, decode, regfile, ALU, branch and writeback per clock.
// One instruction per cycle; instruction and data memories are combinational externals.
// No backpressure; memory strobes are valid only during the executing cycle.
module legv8_core
    import legv8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] instr_addr,
    input  logic [31:0] instruction,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_rdata
);
    logic [63:0] pc;
    flags_t      flags;
    instr_kind_t kind;

    logic [4:0]  rd, rn, rm, ra2, wa;
    logic [5:0]  shamt;
    logic [63:0] rn_val, ra2_val, alu_b, alu_res;
    logic [63:0] pc_plus4, br_target, cb_target, next_pc, wb_data;
    logic [64:0] sum, diff;
    logic        carry, ovf, reg_we;
    alu_op_t     alu_op;
    flags_t      alu_flags;

    assign kind     = decode(instruction[31:21]);
    assign rd       = instruction[4:0];
    assign rn       = instruction[9:5];
    assign rm       = instruction[20:16];
    assign shamt    = instruction[15:10];
    // Stores and CBZ need Rt on the second port instead of Rm.
    assign ra2      = (kind inside {I_STUR, I_STURB, I_CBZ}) ? rd : rm;

    assign pc_plus4  = pc + 64'd4;
    assign br_target = pc + ({{38{instruction[25]}}, instruction[25:0]} << 2);
    assign cb_target = pc + ({{45{instruction[23]}}, instruction[23:5]} << 2);

    reg_file_32x64 u_reg_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (rn),
        .ra2   (ra2),
        .rd1   (rn_val),
        .rd2   (ra2_val),
        .we    (reg_we),
        .wa    (wa),
        .wd    (wb_data)
    );

    // Operand B and ALU operation selection.
    always_comb begin
        alu_b  = ra2_val;
        alu_op = ALU_ADD;
        case (kind)
            I_ADDI:                         alu_b = {52'd0, instruction[21:10]};
            I_LDUR, I_LDURB, I_STUR, I_STURB: alu_b = {{55{instruction[20]}}, instruction[20:12]};
            default: ;
        endcase
        case (kind)
            I_SUBS:  alu_op = ALU_SUB;
            I_AND:   alu_op = ALU_AND;
            I_EOR:   alu_op = ALU_EOR;
            I_LSL:   alu_op = ALU_LSL;
            I_LSR:   alu_op = ALU_LSR;
            I_CBZ:   alu_op = ALU_PASSB;
            default: alu_op = ALU_ADD;
        endcase
    end

    // ALU datapath with carry and signed overflow for add and subtract.
    always_comb begin
        sum     = {1'b0, rn_val} + {1'b0, alu_b};
        diff    = {1'b0, rn_val} + {1'b0, ~alu_b} + 65'd1;
        alu_res = sum[63:0];
        carry   = sum[64];
        ovf     = (rn_val[63] == alu_b[63]) && (sum[63] != rn_val[63]);
        case (alu_op)
            ALU_SUB: begin
                alu_res = diff[63:0];
                carry   = diff[64];
                ovf     = (rn_val[63] != alu_b[63]) && (diff[63] != rn_val[63]);
            end
            ALU_AND:   alu_res = rn_val & alu_b;
            ALU_EOR:   alu_res = rn_val ^ alu_b;
            ALU_LSL:   alu_res = rn_val << shamt;
            ALU_LSR:   alu_res = rn_val >> shamt;
            ALU_PASSB: alu_res = alu_b;
            default: ;
        endcase
        alu_flags.n = alu_res[63];
        alu_flags.z = (alu_res == 64'd0);
        alu_flags.v = ovf;
        alu_flags.c = carry;
    end

    // Next-PC selection.
    always_comb begin
        next_pc = pc_plus4;
        case (kind)
            I_B, I_BL: next_pc = br_target;
            I_CBZ:     if (alu_flags.z) next_pc = cb_target;
            I_BCOND:   if (cond_taken(flags, rd)) next_pc = cb_target;
            I_BR:      next_pc = rn_val;
            default: ;
        endcase
    end

    // Writeback source, destination and enable.
    always_comb begin
        wa      = (kind == I_BL) ? 5'd30 : rd;
        reg_we  = kind inside {I_ADDI, I_ADDS, I_SUBS, I_AND, I_EOR, I_LSL, I_LSR,
                               I_LDUR, I_LDURB, I_BL};
        case (kind)
            I_LDUR:  wb_data = mem_rdata;
            I_LDURB: wb_data = {56'd0, mem_rdata[7:0]};
            I_BL:    wb_data = pc_plus4;
            default: wb_data = alu_res;
        endcase
    end

    assign instr_addr    = pc;
    assign mem_addr      = alu_res;
    assign mem_wdata     = ra2_val;
    // Strobes are suppressed while reset is held so an interrupted access never lands.
    assign mem_we        = !reset && (kind inside {I_STUR, I_STURB});
    assign mem_re        = !reset && (kind inside {I_LDUR, I_LDURB});
    assign mem_xfer_size = (kind inside {I_STUR, I_LDUR})   ? XFER_DWORD :
                           (kind inside {I_STURB, I_LDURB}) ? XFER_BYTE  : XFER_NONE;

    // Program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 64'd0;
        else       pc <= next_pc;
    end

    // NZVC only changes on flag-setting arithmetic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                flags <= '0;
        else if (kind inside {I_ADDS, I_SUBS})    flags <= alu_flags;
    end
endmodule

// File: tb/tb_legv8_core.sv
// Self-checking bench for legv8_core: per-feature programs with an expected-PC scoreboard.
module tb_legv8_core;
    import legv8_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] instr_addr, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] instruction;
    logic        mem_we, mem_re;
    logic [3:0]  mem_xfer_size;

    int errors = 0;
    int checks = 0;
    logic [63:0] pc_q [$];
    logic [63:0] exp_pc;

    typedef struct packed {
        logic [31:0] ins;
        logic [63:0] rdata;
        logic [63:0] nxt;
        logic        we;
        logic        re;
        logic [3:0]  size;
        logic        chk_addr;
        logic [63:0] addr;
        logic        chk_data;
        logic [63:0] wdata;
    } step_t;

    legv8_core dut (
        .clk           (clk),
        .reset         (reset),
        .instr_addr    (instr_addr),
        .instruction   (instruction),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_xfer_size (mem_xfer_size),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_t(logic [10:0] op, logic [4:0] m, logic [5:0] sh, logic [4:0] n, logic [4:0] d);
        return {op, m, sh, n, d};
    endfunction
    function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] n, logic [4:0] d);
        return {OP_ADDI, imm, n, d};
    endfunction
    function automatic logic [31:0] d_t(logic [10:0] op, logic [8:0] a, logic [4:0] n, logic [4:0] t);
        return {op, a, 2'b00, n, t};
    endfunction
    function automatic logic [31:0] cb_t(logic [7:0] op, logic [18:0] a, logic [4:0] t);
        return {op, a, t};
    endfunction
    function automatic logic [31:0] b_t(logic [5:0] op, logic [25:0] a);
        return {op, a};
    endfunction

    function automatic step_t s_alu(logic [31:0] ins, logic [63:0] nxt);
        return '{ins: ins, rdata: 64'd0, nxt: nxt, we: 1'b0, re: 1'b0, size: XFER_NONE,
                 chk_addr: 1'b0, addr: 64'd0, chk_data: 1'b0, wdata: 64'd0};
    endfunction
    function automatic step_t s_st(logic [31:0] ins, logic [63:0] nxt, logic [63:0] a, logic [63:0] d, logic [3:0] sz);
        return '{ins: ins, rdata: 64'd0, nxt: nxt, we: 1'b1, re: 1'b0, size: sz,
                 chk_addr: 1'b1, addr: a, chk_data: 1'b1, wdata: d};
    endfunction
    function automatic step_t s_ld(logic [31:0] ins, logic [63:0] rd, logic [63:0] nxt, logic [63:0] a, logic [3:0] sz);
        return '{ins: ins, rdata: rd, nxt: nxt, we: 1'b0, re: 1'b1, size: sz,
                 chk_addr: 1'b1, addr: a, chk_data: 1'b0, wdata: 64'd0};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        instruction = 32'd0;
        mem_rdata = 64'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pc_q.delete();
    endtask

    task automatic test_reset();
        step_t prog [$];
        do_reset();
        checks++;
        if (instr_addr !== 64'd0) begin
            errors++; $display("FAIL reset_pc0: got %h want 0", instr_addr);
        end
        checks++;
        if (dut.flags !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", dut.flags);
        end
        prog.push_back(s_alu(32'd0, 64'd4));
        prog.push_back(s_alu(32'd0, 64'd8));
        prog.push_back(s_alu(32'd0, 64'd12));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd5), 64'd16, 64'd0, 64'd0, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL reset_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL reset_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL reset_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
    endtask

    // Also leaves X0=5, X1=3 for the following tests; ends at PC 16.
    task automatic test_flags();
        step_t prog [$];
        do_reset();
        prog.push_back(s_alu(i_t(12'd5, 5'd31, 5'd0), 64'd4));
        prog.push_back(s_alu(i_t(12'd3, 5'd31, 5'd1), 64'd8));
        prog.push_back(s_alu(r_t(OP_SUBS, 5'd1, 6'd0, 5'd0, 5'd2), 64'd12));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd2), 64'd16, 64'd0, 64'd2, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL flags_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL flags_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL flags_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
        checks++;
        if (dut.flags !== 4'b0001) begin
            errors++; $display("FAIL flags_nzvc: got %b want 0001", dut.flags);
        end
    endtask

    // Continues from PC 16; ends at PC 48 with X6=1.
    task automatic test_blt();
        step_t prog [$];
        prog.push_back(s_alu(r_t(OP_SUBS, 5'd0, 6'd0, 5'd1, 5'd3), 64'd20));
        prog.push_back(s_alu(r_t(OP_AND, 5'd1, 6'd0, 5'd0, 5'd6), 64'd24));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd3), 64'd28, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, XFER_DWORD));
        prog.push_back(s_alu(cb_t(OP_BCOND, 19'd3, COND_LT), 64'd40));
        prog.push_back(s_alu(cb_t(OP_BCOND, 19'd3, 5'h00), 64'd44));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd6), 64'd48, 64'd0, 64'd1, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL blt_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL blt_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL blt_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
        checks++;
        if (dut.flags !== 4'b1000) begin
            errors++; $display("FAIL blt_nzvc: got %b want 1000", dut.flags);
        end
    endtask

    // Continues from PC 48.
    task automatic test_mem();
        step_t prog [$];
        prog.push_back(s_st(d_t(OP_STUR, 9'd8, 5'd31, 5'd0), 64'd52, 64'd8, 64'd5, XFER_DWORD));
        prog.push_back(s_ld(d_t(OP_LDURB, 9'd8, 5'd31, 5'd4), 64'h1234, 64'd56, 64'd8, XFER_BYTE));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd4), 64'd60, 64'd0, 64'h34, XFER_DWORD));
        prog.push_back(s_ld(d_t(OP_LDUR, 9'd16, 5'd31, 5'd8), 64'hDEAD_BEEF_0123_4567, 64'd64, 64'd16, XFER_DWORD));
        prog.push_back(s_st(d_t(OP_STURB, 9'h1FF, 5'd0, 5'd8), 64'd68, 64'd4, 64'hDEAD_BEEF_0123_4567, XFER_BYTE));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL mem_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_addr) begin
                checks++;
                if (mem_addr !== prog[i].addr) begin
                    errors++; $display("FAIL mem_addr[%0d]: got %h want %h", i, mem_addr, prog[i].addr);
                end
            end
            if (prog[i].chk_data) begin
                checks++;
                if (mem_wdata !== prog[i].wdata) begin
                    errors++; $display("FAIL mem_wdata[%0d]: got %h want %h", i, mem_wdata, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL mem_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
    endtask

    task automatic test_bl_br();
        step_t prog [$];
        do_reset();
        for (int k = 1; k <= 4; k++) prog.push_back(s_alu(32'd0, 64'(4 * k)));
        prog.push_back(s_alu(b_t(OP_BL, 26'd4), 64'h20));
        prog.push_back(s_alu(r_t(OP_BR, 5'd0, 6'd0, 5'd30, 5'd0), 64'h14));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd30), 64'h18, 64'd0, 64'h14, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL blbr_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL blbr_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL blbr_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
    endtask

    task automatic test_cbz();
        step_t prog [$];
        do_reset();
        prog.push_back(s_alu(i_t(12'd5, 5'd31, 5'd0), 64'd4));
        prog.push_back(s_alu(b_t(OP_B, 26'd7), 64'h20));
        prog.push_back(s_alu(cb_t(OP_CBZ, 19'h7FFFE, 5'd31), 64'h18));
        prog.push_back(s_alu(cb_t(OP_CBZ, 19'd5, 5'd0), 64'h1C));
        prog.push_back(s_alu(32'h0000_0000, 64'h20));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd0), 64'h24, 64'd0, 64'd5, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL cbz_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL cbz_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL cbz_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
        checks++;
        if (dut.flags !== 4'b0000) begin
            errors++; $display("FAIL cbz_nzvc: got %b want 0000", dut.flags);
        end
    endtask

    // Shifts, EOR, max immediate and ADDS carry; ends at PC 32.
    task automatic test_alu();
        step_t prog [$];
        do_reset();
        prog.push_back(s_alu(i_t(12'hFFF, 5'd31, 5'd11), 64'd4));
        prog.push_back(s_alu(r_t(OP_LSL, 5'd0, 6'd52, 5'd11, 5'd12), 64'd8));
        prog.push_back(s_alu(r_t(OP_LSR, 5'd0, 6'd60, 5'd12, 5'd13), 64'd12));
        prog.push_back(s_alu(r_t(OP_EOR, 5'd13, 6'd0, 5'd11, 5'd14), 64'd16));
        prog.push_back(s_alu(r_t(OP_ADDS, 5'd12, 6'd0, 5'd12, 5'd15), 64'd20));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd14), 64'd24, 64'd0, 64'hFF0, XFER_DWORD));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd13), 64'd28, 64'd0, 64'hF, XFER_DWORD));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd15), 64'd32, 64'd0, 64'hFFE0_0000_0000_0000, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL alu_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL alu_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL alu_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
        checks++;
        if (dut.flags !== 4'b1001) begin
            errors++; $display("FAIL alu_nzvc: got %b want 1001", dut.flags);
        end
    endtask

    // Dependent back-to-back writes and the X31 sink; continues from PC 32.
    task automatic test_back_to_back();
        step_t prog [$];
        prog.push_back(s_alu(i_t(12'd7, 5'd31, 5'd9), 64'd36));
        prog.push_back(s_alu(i_t(12'd1, 5'd9, 5'd9), 64'd40));
        prog.push_back(s_alu(i_t(12'd9, 5'd31, 5'd31), 64'd44));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd9), 64'd48, 64'd0, 64'd8, XFER_DWORD));
        prog.push_back(s_st(d_t(OP_STUR, 9'd0, 5'd31, 5'd31), 64'd52, 64'd0, 64'd0, XFER_DWORD));
        foreach (prog[i]) begin
            instruction = prog[i].ins; mem_rdata = prog[i].rdata; pc_q.push_back(prog[i].nxt); #1;
            checks++;
            if ({mem_we, mem_re, mem_xfer_size} !== {prog[i].we, prog[i].re, prog[i].size}) begin
                errors++; $display("FAIL b2b_strobe[%0d]: got %b%b/%0d want %b%b/%0d", i, mem_we, mem_re, mem_xfer_size, prog[i].we, prog[i].re, prog[i].size);
            end
            if (prog[i].chk_data) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {prog[i].addr, prog[i].wdata}) begin
                    errors++; $display("FAIL b2b_store[%0d]: got %h/%h want %h/%h", i, mem_addr, mem_wdata, prog[i].addr, prog[i].wdata);
                end
            end
            @(posedge clk); #1;
            exp_pc = pc_q.pop_front(); checks++;
            if (instr_addr !== exp_pc) begin
                errors++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, instr_addr, exp_pc);
            end
        end
    endtask

    // Reset asserted in the middle of a store cycle.
    task automatic test_reset_mid();
        instruction = d_t(OP_STUR, 9'd0, 5'd31, 5'd9);
        #1;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_we: got %b want 1", mem_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_re, instr_addr} !== {1'b0, 1'b0, 64'd0}) begin
            errors++; $display("FAIL midrst_async: got we=%b re=%b pc=%h want 0 0 0", mem_we, mem_re, instr_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        pc_q.delete();
        pc_q.push_back(64'd4);
        #1;
        checks++;
        if ({mem_we, mem_wdata} !== {1'b1, 64'd0}) begin
            errors++; $display("FAIL midrst_x9: got we=%b data=%h want 1 0", mem_we, mem_wdata);
        end
        @(posedge clk); #1;
        exp_pc = pc_q.pop_front(); checks++;
        if (instr_addr !== exp_pc) begin
            errors++; $display("FAIL midrst_pc: got %h want %h", instr_addr, exp_pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        instruction = 32'd0;
        mem_rdata = 64'd0;
        test_reset();
        test_flags();
        test_blt();
        test_mem();
        test_bl_br();
        test_cbz();
        test_alu();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
